// File: rtl/mult_pkg.sv
// Shared definitions for the parametrised Booth multiplier: FSM states,
// step-counter sizing and the radix-2 Booth operation codes.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth op-codes, indexed by {q0, q(-1)}; 2'b11 is also a no-op.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Counter must hold WIDTH+1 steps with margin.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/multiplicador_param_booth_step.sv
// One radix-2 Booth step: add/subtract the multiplicand into the upper half,
// then arithmetic-shift the whole {A, Q, q(-1)} register right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH+3:0] acc,      // {A[WIDTH+1:0], Q[WIDTH:0], q(-1)}
  input  logic [WIDTH+1:0]   mcand,    // multiplicand extended to A width
  output logic [2*WIDTH+3:0] next_acc
);

  logic [WIDTH+1:0] a_cur;
  logic [WIDTH+1:0] a_sum;

  assign a_cur = acc[2*WIDTH+3:WIDTH+2];

  // Select add/sub/no-op from {q0, q(-1)}, then shift right arithmetically.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments, and every output
    // gets a default first so no path leaves it unassigned (no latch).
    a_sum = a_cur;
    case (acc[1:0])
      BOOTH_SUB:         a_sum = a_cur - mcand;
      BOOTH_ADD:         a_sum = a_cur + mcand;
      BOOTH_NOP, 2'b11:  a_sum = a_cur;
      default:           a_sum = a_cur;
    endcase
    next_acc = {a_sum[WIDTH+1], a_sum, acc[WIDTH+1:1]};
  end

endmodule

// File: rtl/multiplicador_param.sv
// Parametrised sequential multiplier (signed/unsigned) using one radix-2
// Booth step per clock, with a one-cycle short path for zero operands and
// the St/Idle/Done handshake used by the MIPS datapath.
module multiplicador_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               St,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic               Idle,
  output logic               Done,
  output logic [2*WIDTH-1:0] Produto
);

  localparam int CW = cnt_width(WIDTH);
  localparam int AW = 2 * WIDTH + 4;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    next_acc;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH:0]   cand_ext;
  logic [WIDTH:0]   plier_ext;
  logic             zero_op;

  // Operands widened by one bit so unsigned values stay positive under Booth.
  assign cand_ext  = {Signed & Multiplicando[WIDTH-1], Multiplicando};
  assign plier_ext = {Signed & Multiplicador[WIDTH-1], Multiplicador};
  assign zero_op   = (Multiplicando == '0) || (Multiplicador == '0);

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .mcand    (mcand),
    .next_acc (next_acc)
  );

  // Control FSM, step counter, datapath registers and registered handshake.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      Idle    <= 1'b1;
      Done    <= 1'b0;
      Produto <= '0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      case (state)
        IDLE: begin
          if (St) begin
            Idle <= 1'b0;
            if (zero_op) begin
              Produto <= '0;
              Done    <= 1'b1;
              state   <= DONE;
            end else begin
              mcand <= {cand_ext[WIDTH], cand_ext};
              acc   <= {{(WIDTH + 2){1'b0}}, plier_ext, 1'b0};
              count <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc   <= next_acc;
          count <= count + CW'(1);
          if (count == LAST_STEP) begin
            Produto <= next_acc[2*WIDTH:1];
            Done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          Idle  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Idle  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_param.sv
// Self-checking bench for multiplicador_param at WIDTH=16: directed vector
// table, protocol and reset sequences, and randomized operations compared
// against an arithmetic reference model.
module tb_multiplicador_param;

  localparam int W = 16;

  logic           Clk;
  logic           Rst_n;
  logic           St;
  logic           Signed;
  logic [W-1:0]   Multiplicando;
  logic [W-1:0]   Multiplicador;
  logic           Idle;
  logic           Done;
  logic [2*W-1:0] Produto;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_prod;

  multiplicador_param #(.WIDTH(W)) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .St            (St),
    .Signed        (Signed),
    .Multiplicando (Multiplicando),
    .Multiplicador (Multiplicador),
    .Idle          (Idle),
    .Done          (Done),
    .Produto       (Produto)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           sgn;
    logic [2*W-1:0] prod;
    int             lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Product of the operands read as signed or unsigned integers, kept to 2*W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return (2*W)'(x * y);
  endfunction

  // Issue one operation, measure edges from capture to DONE entry, and check
  // that Produto holds its previous value until then and Done is one cycle.
  task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic sgn,
                        output logic [2*W-1:0] prod, output int lat);
    int n;
    bit held;
    n = 0;
    while (!Idle && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("idle_wait", 64'(Idle), 64'd1);
    Multiplicando = mc;
    Multiplicador = mp;
    Signed        = sgn;
    St            = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St            = 1'b0;
    Multiplicando = W'($urandom);
    Multiplicador = W'($urandom);
    Signed        = 1'($urandom);
    held = 1'b1;
    n    = 0;
    while (!Done && n < 100) begin
      if (Produto !== last_prod) held = 1'b0;
      check_idle_low: if (Idle !== 1'b0) held = 1'b0;
      @(negedge Clk);
      n++;
    end
    check("done_seen", 64'(Done), 64'd1);
    check("produto_hold", 64'(held), 64'd1);
    prod = Produto;
    lat  = n;
    @(negedge Clk);
    check("done_pulse", 64'(Done), 64'd0);
    check("idle_back", 64'(Idle), 64'd1);
    last_prod = prod;
  endtask

  initial begin
    logic [2*W-1:0] prod;
    logic [W-1:0]   mc;
    logic [W-1:0]   mp;
    logic           sgn;
    int             lat;
    int             pulses;

    vecs[0] = '{mc: 16'd12,    mp: 16'd0,     sgn: 1'b0, prod: 32'd0,          lat: 0};
    vecs[1] = '{mc: 16'd12,    mp: 16'd10,    sgn: 1'b0, prod: 32'd120,        lat: 17};
    vecs[2] = '{mc: 16'd200,   mp: 16'd3,     sgn: 1'b0, prod: 32'd600,        lat: 17};
    vecs[3] = '{mc: 16'hFFFF,  mp: 16'hFFFF,  sgn: 1'b0, prod: 32'hFFFE_0001,  lat: 17};
    vecs[4] = '{mc: 16'hFFFD,  mp: 16'h0005,  sgn: 1'b1, prod: 32'hFFFF_FFF1,  lat: 17};
    vecs[5] = '{mc: 16'h8000,  mp: 16'h8000,  sgn: 1'b1, prod: 32'h4000_0000,  lat: 17};
    vecs[6] = '{mc: 16'h7FFF,  mp: 16'h8000,  sgn: 1'b1, prod: 32'hC000_8000,  lat: 17};

    Rst_n = 1'b0;
    St = 1'b0;
    Signed = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;
    last_prod = '0;
    repeat (3) @(negedge Clk);
    check("rst_idle", 64'(Idle), 64'd1);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_produto", 64'(Produto), 64'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].mc, vecs[i].mp, vecs[i].sgn, prod, lat);
      check($sformatf("vec%0d_prod", i), 64'(prod), 64'(vecs[i].prod));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Second St during CALC is ignored
    Multiplicando = 16'd7;
    Multiplicador = 16'd9;
    Signed = 1'b0;
    St = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    repeat (4) @(negedge Clk);
    Multiplicando = 16'd100;
    Multiplicador = 16'd100;
    St = 1'b1;
    @(negedge Clk);
    St = 1'b0;
    pulses = 0;
    prod = '0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        pulses++;
        prod = Produto;
      end
      @(negedge Clk);
    end
    check("proto_pulses", 64'(pulses), 64'd1);
    check("proto_prod", 64'(prod), 64'd63);
    check("proto_idle", 64'(Idle), 64'd1);
    last_prod = Produto;

    // Reset in the middle of CALC
    Multiplicando = 16'd1234;
    Multiplicador = 16'd567;
    Signed = 1'b0;
    St = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    St = 1'b0;
    repeat (7) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("midrst_idle", 64'(Idle), 64'd1);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_produto", 64'(Produto), 64'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    last_prod = '0;
    run_op(16'd6, 16'd7, 1'b0, prod, lat);
    check("after_rst_prod", 64'(prod), 64'd42);
    check("after_rst_lat", 64'(lat), 64'd17);

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      mc  = W'($urandom);
      mp  = W'($urandom);
      sgn = 1'($urandom);
      if ($urandom_range(0, 7) == 0) mc = '0;
      if ($urandom_range(0, 7) == 0) mp = '0;
      if ($urandom_range(0, 9) == 0) begin
        mc = sgn ? 16'h8000 : 16'hFFFF;
        mp = sgn ? 16'h8000 : 16'hFFFF;
      end
      run_op(mc, mp, sgn, prod, lat);
      check($sformatf("rnd%0d_prod", i), 64'(prod), 64'(ref_mul(mc, mp, sgn)));
      check($sformatf("rnd%0d_lat", i), 64'(lat),
            64'((mc == '0 || mp == '0) ? 0 : W + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplicador_param.md
Name: multiplicador_param

Overview:
Parametrised sequential multiplier, the successor to the fixed 16x16 shift-add multiplier. It computes one radix-2 Booth step per clock. Operand width is set by parameter and a per-operation Signed mode selects two's-complement or unsigned operands. Zero operands take a short path that finishes in one cycle. The block sits beside the ALU in the MIPS datapath and serves MULT/MULTU through the same St/Idle/Done handshake as the original block.

Parameters:
WIDTH, 16, operand width in bits (legal range 4..32); Produto is 2*WIDTH bits.

Ports:
Clk  input  1  system clock, rising edge.
Rst_n  input  1  asynchronous active-low reset.
St  input  1  start request; sampled only while Idle=1.
Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with St.
Multiplicando  input  WIDTH  multiplicand; sampled with St.
Multiplicador  input  WIDTH  multiplier; sampled with St.
Idle  output  1  high when the block is in IDLE and ready to accept St.
Done  output  1  one-cycle pulse; Produto is valid while Done is high.
Produto  output  2*WIDTH  result register; holds its value until the next accepted St or reset.

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, Idle=1, Done=0, Produto=0, step counter=0, internal accumulator cleared. Reset during CALC abandons the operation; no Done is produced.
- States: IDLE, CALC, DONE. All state transitions occur on rising Clk edges.
- IDLE: Idle=1. If St=1 at edge k:
  - Capture the operands and Signed.
  - Extend both operands to WIDTH+1 bits: sign-extend if Signed=1, zero-extend if Signed=0.
  - If either operand is zero, go to DONE at edge k and load Produto=0 (the zero short path).
  - Otherwise clear the accumulator, clear the Booth extra bit q(-1), set count=0, and go to CALC.
- CALC: Idle=0, Done=0.
  - Each edge examines {q0, q(-1)}. 10 subtracts the multiplicand from the upper half; 01 adds it; 00 and 11 leave the upper half unchanged.
  - Then arithmetic-shift right the {A, Q, q(-1)} register by 1; count increments.
  - Exactly WIDTH+1 steps. On the edge that performs step WIDTH+1, load Produto with the low 2*WIDTH bits of {A, Q} and go to DONE.
  - The A register is WIDTH+2 bits wide so no step overflows.
- DONE: Done=1 and Idle=0 for exactly one cycle; next edge goes to IDLE unconditionally.
- Latency: with St accepted at edge k, Done is high in the cycle after edge k+WIDTH+1 (normal path) or after edge k (zero path).
- St while Idle=0 (CALC or DONE) is ignored. Operand and Signed changes after the capture edge have no effect.
- St held high continuously: a new operation is accepted on the first edge at which Idle=1, i.e. back-to-back operations separated by the one-cycle DONE state.
- Produto changes only on the edge entering DONE, or on reset.
- Signed min*min (e.g. 0x8000*0x8000 at WIDTH=16) must give +2^(2*WIDTH-2) exactly.
- Unsigned max*max must give (2^WIDTH-1)^2 exactly.

Decomposition:
- Shared package mult_pkg holds:
  - The state enum (IDLE, CALC, DONE).
  - A function returning the counter width, clog2(WIDTH+2).
  - The Booth op-code constants (NOP, ADD, SUB).
- One sub-module, booth_step: combinational, parametrised by WIDTH. It takes {A, Q, q(-1)} and the extended multiplicand and returns the next {A, Q, q(-1)}.
- The top level holds the FSM, the counter, the operand registers and the Produto register.

Test Plan (WIDTH=16):
- Zero path: St with 12*0, Signed=0 -> Done one cycle after the capture edge, Produto=0, Idle back to 1 on the following edge.
- Unsigned small operands: 12*10 -> Produto=120 with Done exactly 17 cycles after the capture edge. Then 200*3 -> Produto=600, and the previous result 120 is held until that DONE.
- Unsigned extremes: 0xFFFF*0xFFFF with Signed=0 -> Produto=0xFFFE0001.
- Signed operands:
  - 0xFFFD*0x0005 (-3*5) -> 0xFFFFFFF1.
  - 0x8000*0x8000 -> 0x40000000.
  - 0x7FFF*0x8000 -> 0xC0008000.
- Protocol: pulse St with 7*9, then pulse St again at cycle 5 of CALC with 100*100 -> the second request is ignored, Produto=63, exactly one Done pulse.
- Reset mid-operation: drop Rst_n at cycle 8 of CALC -> immediately Idle=1, Done=0, Produto=0. After release, 6*7 completes normally with Produto=42.
